// File: rtl/user_wb_slot_sequencer_if.sv
// Bus bundle between the management Wishbone port, the slot sequencer and the
// per-slot downstream ports. The sequencer uses the slave view; the host side uses master.
interface user_wb_slot_sequencer_if #(
    parameter int NSLV = 4
);
    logic                 wbs_cyc_i;
    logic                 wbs_stb_i;
    logic                 wbs_we_i;
    logic [3:0]           wbs_sel_i;
    logic [31:0]          wbs_adr_i;
    logic [31:0]          wbs_dat_i;
    logic                 wbs_ack_o;
    logic [31:0]          wbs_dat_o;
    logic                 s_cyc_o;
    logic [NSLV-1:0]      s_stb_o;
    logic                 s_we_o;
    logic [3:0]           s_sel_o;
    logic [31:0]          s_adr_o;
    logic [31:0]          s_dat_o;
    logic [NSLV-1:0]      s_ack_i;
    logic [NSLV*32-1:0]   s_dat_i;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        input  s_ack_i, s_dat_i
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        output s_ack_i, s_dat_i
    );
endinterface

// File: rtl/user_wb_slot_sequencer.sv
// Shares the user-area Wishbone slave port among NSLV sub-project slots: decodes the
// address to a slot, re-issues the access there, and returns one registered ack (or a timeout error).
module user_wb_slot_sequencer #(
    parameter int          NSLV     = 4,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter logic [31:0] ADR_MASK = 32'hFFF0_0000,
    parameter int          SEL_LSB  = 16,
    parameter int          TIMEOUT  = 255
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n_i,
    user_wb_slot_sequencer_if.slave bus,
    output logic                    busy_o,
    output logic [7:0]              err_cnt_o
);
    localparam int SW = $clog2(NSLV);
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {IDLE, FWD, ACK, ERR} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [7:0]    wait_q, wait_d;
    logic [7:0]    err_q, err_d;
    logic          ack_q, ack_d;
    logic [31:0]   rdat_q, rdat_d;

    logic hit;
    logic req;

    assign hit = (bus.wbs_adr_i & ADR_MASK) == BASE_ADR;
    assign req = bus.wbs_cyc_i && bus.wbs_stb_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            slot_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            wait_q  <= '0;
            err_q   <= '0;
            ack_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
            rdat_q  <= rdat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        wait_d  = wait_q;
        err_d   = err_q;
        ack_d   = 1'b0;
        rdat_d  = rdat_q;
        case (state_q)
            IDLE: begin
                if (req && hit) begin
                    slot_d  = bus.wbs_adr_i[SEL_LSB +: SW];
                    we_d    = bus.wbs_we_i;
                    sel_d   = bus.wbs_sel_i;
                    adr_d   = bus.wbs_adr_i;
                    dat_d   = bus.wbs_dat_i;
                    wait_d  = '0;
                    state_d = FWD;
                end else if (req) begin
                    ack_d   = 1'b1;
                    rdat_d  = ERR_DATA;
                    state_d = ERR;
                end
            end
            FWD: begin
                // An abort by the host wins over a same-cycle slot ack or timeout.
                if (!bus.wbs_cyc_i) begin
                    state_d = IDLE;
                end else if (bus.s_ack_i[slot_q]) begin
                    ack_d   = 1'b1;
                    rdat_d  = bus.s_dat_i[32*slot_q +: 32];
                    state_d = ACK;
                end else if (wait_q == 8'(TIMEOUT - 1)) begin
                    ack_d   = 1'b1;
                    rdat_d  = ERR_DATA;
                    state_d = ERR;
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ACK:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobe and cycle decode straight from the state register so an async reset drops them at once.
    assign bus.s_cyc_o   = (state_q == FWD);
    assign bus.s_stb_o   = (state_q == FWD) ? (NSLV'(1) << slot_q) : '0;
    assign bus.s_we_o    = we_q;
    assign bus.s_sel_o   = sel_q;
    assign bus.s_adr_o   = adr_q;
    assign bus.s_dat_o   = dat_q;
    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_dat_o = rdat_q;
    assign busy_o        = (state_q != IDLE);
    assign err_cnt_o     = err_q;
endmodule

// File: tb/tb_user_wb_slot_sequencer.sv
// Directed bench for the slot sequencer: main instance with TIMEOUT=255, a second
// instance with TIMEOUT=2 used to drive the error counter into saturation quickly.
module tb_user_wb_slot_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy, busy2;
    logic [7:0] err_cnt, err_cnt2;
    int         n_tests = 0;
    int         n_fail = 0;

    user_wb_slot_sequencer_if #(.NSLV(4)) bus ();
    user_wb_slot_sequencer_if #(.NSLV(4)) bus2 ();

    user_wb_slot_sequencer #(.NSLV(4), .TIMEOUT(255)) dut (
        .wb_clk_i  (clk),
        .wb_rst_n_i(rst_n),
        .bus       (bus),
        .busy_o    (busy),
        .err_cnt_o (err_cnt)
    );

    user_wb_slot_sequencer #(.NSLV(4), .TIMEOUT(2)) dut_sat (
        .wb_clk_i  (clk),
        .wb_rst_n_i(rst_n),
        .bus       (bus2),
        .busy_o    (busy2),
        .err_cnt_o (err_cnt2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mgmt_req(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                            input logic [31:0] dat);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = sel;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
    endtask

    task automatic mgmt_idle();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
    endtask

    initial begin
        int n;
        int acks;
        mgmt_idle();
        bus.s_ack_i    = 4'h0;
        bus.s_dat_i    = '0;
        bus2.wbs_cyc_i = 1'b0;
        bus2.wbs_stb_i = 1'b0;
        bus2.wbs_we_i  = 1'b0;
        bus2.wbs_sel_i = 4'h0;
        bus2.wbs_adr_i = 32'h0;
        bus2.wbs_dat_i = 32'h0;
        bus2.s_ack_i   = 4'h0;
        bus2.s_dat_i   = '0;
        bus.s_dat_i[2*32 +: 32] = 32'h1234_5678;
        bus.s_dat_i[1*32 +: 32] = 32'h0BAD_F00D;
        bus.s_dat_i[0*32 +: 32] = 32'hCAFE_0000;

        // Reset state
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ack", 32'(bus.wbs_ack_o), 32'h0);
        check("rst_dat", bus.wbs_dat_o, 32'h0);
        check("rst_stb", 32'(bus.s_stb_o), 32'h0);
        check("rst_cyc", 32'(bus.s_cyc_o), 32'h0);
        check("rst_err", 32'(err_cnt), 32'h0);
        rst_n = 1'b1;
        tick();

        // T1: read slot 2, ack in first FWD cycle
        mgmt_req(1'b0, 4'hF, 32'h3002_0004, 32'h0);
        check("t1_c0_stb", 32'(bus.s_stb_o), 32'h0);
        tick();
        check("t1_c1_stb", 32'(bus.s_stb_o), 32'h4);
        check("t1_c1_cyc", 32'(bus.s_cyc_o), 32'h1);
        check("t1_c1_adr", bus.s_adr_o, 32'h3002_0004);
        check("t1_c1_ack", 32'(bus.wbs_ack_o), 32'h0);
        bus.s_ack_i = 4'b0100;
        tick();
        check("t1_c2_ack", 32'(bus.wbs_ack_o), 32'h1);
        check("t1_c2_dat", bus.wbs_dat_o, 32'h1234_5678);
        check("t1_c2_stb", 32'(bus.s_stb_o), 32'h0);
        mgmt_idle();
        bus.s_ack_i = 4'h0;
        tick();
        check("t1_c3_ack", 32'(bus.wbs_ack_o), 32'h0);
        check("t1_c3_busy", 32'(busy), 32'h0);

        // T4: decode miss
        mgmt_req(1'b0, 4'hF, 32'h2000_0000, 32'h0);
        tick();
        check("t4_ack", 32'(bus.wbs_ack_o), 32'h1);
        check("t4_dat", bus.wbs_dat_o, 32'hDEAD_BEEF);
        check("t4_stb", 32'(bus.s_stb_o), 32'h0);
        check("t4_err", 32'(err_cnt), 32'h0);
        mgmt_idle();
        tick();
        check("t4_ack_end", 32'(bus.wbs_ack_o), 32'h0);

        // T2: write slot 1, slot acks in its 5th FWD cycle
        mgmt_req(1'b1, 4'b0011, 32'h3001_0010, 32'hA5A5_A5A5);
        tick();
        mgmt_req(1'b0, 4'hF, 32'h0, 32'h0);
        bus.wbs_we_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t2_stb", 32'(bus.s_stb_o), 32'h2);
            check("t2_dat", bus.s_dat_o, 32'hA5A5_A5A5);
            check("t2_sel", 32'(bus.s_sel_o), 32'h3);
            check("t2_we", 32'(bus.s_we_o), 32'h1);
            check("t2_ack_early", 32'(bus.wbs_ack_o), 32'h0);
            if (i == 4) bus.s_ack_i = 4'b0010;
            tick();
        end
        bus.s_ack_i = 4'h0;
        check("t2_ack", 32'(bus.wbs_ack_o), 32'h1);
        mgmt_idle();
        tick();
        check("t2_ack_single", 32'(bus.wbs_ack_o), 32'h0);

        // T3: slot 3 never acks
        check("t3_err_before", 32'(err_cnt), 32'h0);
        mgmt_req(1'b0, 4'hF, 32'h3003_0000, 32'h0);
        tick();
        n = 0;
        while (bus.s_stb_o == 4'b1000 && bus.wbs_ack_o == 1'b0 && n < 400) begin
            n++;
            tick();
        end
        check("t3_stb_cycles", n, 32'd255);
        check("t3_ack", 32'(bus.wbs_ack_o), 32'h1);
        check("t3_dat", bus.wbs_dat_o, 32'hDEAD_BEEF);
        check("t3_err", 32'(err_cnt), 32'h1);
        mgmt_idle();
        tick();

        // T5: stray ack on slot 1, then abort with simultaneous slot-0 ack
        mgmt_req(1'b0, 4'hF, 32'h3000_0008, 32'h0);
        tick();
        check("t5_stb", 32'(bus.s_stb_o), 32'h1);
        bus.s_ack_i = 4'b0010;
        tick();
        check("t5_stray_ack", 32'(bus.wbs_ack_o), 32'h0);
        check("t5_stray_stb", 32'(bus.s_stb_o), 32'h1);
        bus.s_ack_i = 4'b0001;
        mgmt_idle();
        tick();
        bus.s_ack_i = 4'h0;
        check("t5_abort_ack", 32'(bus.wbs_ack_o), 32'h0);
        check("t5_abort_busy", 32'(busy), 32'h0);
        check("t5_abort_stb", 32'(bus.s_stb_o), 32'h0);
        check("t5_abort_cyc", 32'(bus.s_cyc_o), 32'h0);
        tick();
        check("t5_no_late_ack", 32'(bus.wbs_ack_o), 32'h0);

        // T6: asynchronous reset in the middle of FWD
        mgmt_req(1'b0, 4'hF, 32'h3000_0000, 32'h0);
        tick();
        check("t6_busy", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_stb", 32'(bus.s_stb_o), 32'h0);
        check("t6_rst_cyc", 32'(bus.s_cyc_o), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_err", 32'(err_cnt), 32'h0);
        check("t6_rst_dat", bus.wbs_dat_o, 32'h0);
        mgmt_idle();
        tick();
        check("t6_rst_ack", 32'(bus.wbs_ack_o), 32'h0);
        rst_n = 1'b1;
        tick();
        mgmt_req(1'b0, 4'hF, 32'h3000_0000, 32'h0);
        tick();
        check("t6_re_stb", 32'(bus.s_stb_o), 32'h1);
        bus.s_ack_i = 4'b0001;
        tick();
        bus.s_ack_i = 4'h0;
        check("t6_re_ack", 32'(bus.wbs_ack_o), 32'h1);
        check("t6_re_dat", bus.wbs_dat_o, 32'hCAFE_0000);
        mgmt_idle();
        tick();

        // Error counter saturation on the short-timeout instance
        bus2.wbs_cyc_i = 1'b1;
        bus2.wbs_stb_i = 1'b1;
        bus2.wbs_adr_i = 32'h3000_0000;
        acks = 0;
        n = 0;
        while (acks < 300 && n < 2000) begin
            tick();
            n++;
            if (bus2.wbs_ack_o) begin
                acks++;
                if (acks == 10)  check("sat_err_10", 32'(err_cnt2), 32'd10);
                if (acks == 255) check("sat_err_255", 32'(err_cnt2), 32'hFF);
            end
        end
        check("sat_acks", acks, 32'd300);
        check("sat_err_300", 32'(err_cnt2), 32'hFF);
        check("sat_dat", bus2.wbs_dat_o, 32'hDEAD_BEEF);
        bus2.wbs_cyc_i = 1'b0;
        bus2.wbs_stb_i = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
